ins_sequencer: RTL and testbench

Parametrised instruction sequencer for the model computer. It fetches an opcode, decodes it into one-hot control lines, and holds them for a programmable number of execute cycles. It also drives PC/IR strobes, resolves unconditional and conditional jumps, latches halt, and flags illegal opcodes. It sits between instruction memory / IR register and the datapath, and replaces the purely combinational opcode decoder. With default parameters the one-hot ordering is mova, movb, movc, movd, add, sub, jmp, jg, in1, out1, movi, halt (MSB to LSB).

---
 rtl/ins_sequencer_if.sv | 29 ++
 rtl/ins_sequencer.sv | 126 ++++++++++++
 tb/tb_ins_sequencer.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/ins_sequencer_if.sv
// rtl/ins_sequencer_if.sv - control and status bundle between the sequencer and the IR/PC/datapath
// The master side is the sequencer itself; the slave side is the IR/PC/datapath it steers.
interface ins_sequencer_if #(
    parameter int OPW  = 4,
    parameter int NINS = 12
);
    logic            en;
    logic            start;
    logic            mem_rdy;
    logic [OPW-1:0]  ir;
    logic            gt_flag;
    logic [NINS-1:0] dec;
    logic            ir_load;
    logic            pc_inc;
    logic            pc_load;
    logic            busy;
    logic            halted;
    logic            illegal;

    modport master (
        input  en, start, mem_rdy, ir, gt_flag,
        output dec, ir_load, pc_inc, pc_load, busy, halted, illegal
    );

    modport slave (
        output en, start, mem_rdy, ir, gt_flag,
        input  dec, ir_load, pc_inc, pc_load, busy, halted, illegal
    );
endinterface

// File: rtl/ins_sequencer.sv
// rtl/ins_sequencer.sv - fetch/decode/execute sequencer with one-hot decode and jump/halt resolution
// Opcode BASE+k lights dec[NINS-1-k] for EXEC_CYC cycles; en=0 freezes all state and masks strobes.
module ins_sequencer #(
    parameter int OPW      = 4,
    parameter int NINS     = 12,
    parameter int BASE     = 4,
    parameter int JMP_IDX  = 5,
    parameter int JG_IDX   = 4,
    parameter int HALT_IDX = 0,
    parameter int EXEC_CYC = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    ins_sequencer_if.master    bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_HALTED
    } state_t;

    localparam int              CW     = 4;
    localparam logic [OPW:0]    BASE_W = (OPW+1)'(BASE);
    localparam logic [OPW:0]    LIM_W  = (OPW+1)'(BASE + NINS);

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [NINS-1:0] dec_q, dec_d;
    logic            illegal_q, illegal_d;
    logic            ir_load, pc_inc, pc_load;

    logic [OPW:0]    ir_ext;
    logic [OPW:0]    ir_off;
    logic            ir_legal;
    logic [NINS-1:0] ir_onehot;

    // One extra bit so BASE+NINS == 2^OPW is still representable as the upper bound.
    always_comb begin
        ir_ext    = {1'b0, bus.ir};
        ir_off    = ir_ext - BASE_W;
        ir_legal  = (ir_ext >= BASE_W) && (ir_ext < LIM_W);
        ir_onehot = '0;
        for (int k = 0; k < NINS; k++) begin
            if (ir_off == (OPW+1)'(k)) begin
                ir_onehot[NINS-1-k] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            dec_q     <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            dec_q     <= dec_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        dec_d     = dec_q;
        illegal_d = illegal_q;
        ir_load   = 1'b0;
        pc_inc    = 1'b0;
        pc_load   = 1'b0;
        if (bus.en) begin
            case (state_q)
                S_IDLE: begin
                    if (bus.start) state_d = S_FETCH;
                end
                S_FETCH: begin
                    if (bus.mem_rdy) begin
                        ir_load = 1'b1;
                        pc_inc  = 1'b1;
                        state_d = S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (ir_legal) begin
                        dec_d   = ir_onehot;
                        cnt_d   = CW'(EXEC_CYC - 1);
                        state_d = S_EXEC;
                    end else begin
                        illegal_d = 1'b1;
                        dec_d     = '0;
                        state_d   = S_FETCH;
                    end
                end
                S_EXEC: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - 1'b1;
                    end else if (dec_q[HALT_IDX]) begin
                        state_d = S_HALTED;
                    end else begin
                        // gt_flag is taken live in the final execute cycle, not latched at decode.
                        pc_load = dec_q[JMP_IDX] | (dec_q[JG_IDX] & bus.gt_flag);
                        state_d = S_FETCH;
                    end
                end
                S_HALTED: begin
                    if (bus.start) begin
                        state_d   = S_FETCH;
                        illegal_d = 1'b0;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign bus.dec     = (state_q == S_EXEC && bus.en) ? dec_q : '0;
    assign bus.ir_load = ir_load;
    assign bus.pc_inc  = pc_inc;
    assign bus.pc_load = pc_load;
    assign bus.busy    = (state_q == S_FETCH) || (state_q == S_DECODE) || (state_q == S_EXEC);
    assign bus.halted  = (state_q == S_HALTED);
    assign bus.illegal = illegal_q;
endmodule

// File: tb/tb_ins_sequencer.sv
// tb/tb_ins_sequencer.sv - scoreboard bench for ins_sequencer (default and EXEC_CYC=3 instances)
module tb_ins_sequencer;
    typedef struct {
        int          cyc;
        logic [11:0] dec;
        logic        il;
        logic        pi;
        logic        pl;
    } ev_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   n_total;
    int   n_pass;
    ev_t  q0[$];
    ev_t  q3[$];

    ins_sequencer_if #(.OPW(4), .NINS(12)) b0 ();
    ins_sequencer_if #(.OPW(4), .NINS(12)) b3 ();

    ins_sequencer #(.EXEC_CYC(1)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(b0));
    ins_sequencer #(.EXEC_CYC(3)) u_dut3 (.clk(clk), .rst_n(rst_n), .bus(b3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic int qsz(input int w);
        return (w == 0) ? q0.size() : q3.size();
    endfunction

    function automatic ev_t qfront(input int w);
        return (w == 0) ? q0[0] : q3[0];
    endfunction

    function automatic void qpop(input int w);
        if (w == 0) void'(q0.pop_front());
        else        void'(q3.pop_front());
    endfunction

    task automatic mon_step(input int w, input logic [14:0] obs);
        ev_t e;
        bit  more;
        more = 1'b1;
        while (more) begin
            if (qsz(w) == 0) begin
                more = 1'b0;
            end else begin
                e = qfront(w);
                if (e.cyc >= cyc) begin
                    more = 1'b0;
                end else begin
                    n_total++;
                    $display("FAIL missing_event dut%0d: expected %0h at cycle %0d, still absent at cycle %0d",
                             w, {e.dec, e.il, e.pi, e.pl}, e.cyc, cyc);
                    qpop(w);
                end
            end
        end
        if (obs != '0) begin
            if (qsz(w) == 0) begin
                n_total++;
                $display("FAIL unexpected_event dut%0d: got %0h at cycle %0d, expected none", w, obs, cyc);
            end else begin
                e = qfront(w);
                qpop(w);
                check($sformatf("event_cycle_dut%0d", w), cyc, e.cyc);
                check($sformatf("event_outputs_dut%0d", w), {17'b0, obs}, {17'b0, e.dec, e.il, e.pi, e.pl});
            end
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            mon_step(0, {b0.dec, b0.ir_load, b0.pc_inc, b0.pc_load});
            mon_step(3, {b3.dec, b3.ir_load, b3.pc_inc, b3.pc_load});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called at the start of a FETCH cycle of the default instance with mem_rdy high.
    task automatic instr0(input logic [3:0] op, input logic gt, input logic [11:0] edec, input logic epl);
        b0.ir      = op;
        b0.gt_flag = gt;
        q0.push_back('{cyc, 12'h000, 1'b1, 1'b1, 1'b0});
        if (edec != 12'h000) begin
            q0.push_back('{cyc + 2, edec, 1'b0, 1'b0, epl});
            repeat (3) tick();
        end else begin
            repeat (2) tick();
        end
    endtask

    function automatic logic [14:0] outs0();
        return {b0.dec, b0.ir_load, b0.pc_inc, b0.pc_load};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int f;
        n_total = 0;
        n_pass  = 0;
        rst_n   = 1'b0;
        b0.en = 1'b1; b0.start = 1'b0; b0.mem_rdy = 1'b1; b0.ir = 4'h0; b0.gt_flag = 1'b0;
        b3.en = 1'b1; b3.start = 1'b0; b3.mem_rdy = 1'b1; b3.ir = 4'h0; b3.gt_flag = 1'b0;
        repeat (3) tick();
        check("reset_outputs", {14'b0, outs0(), b0.busy, b0.halted, b0.illegal}, 32'h0);
        rst_n = 1'b1;
        check("post_release_outputs", {14'b0, outs0(), b0.busy, b0.halted, b0.illegal}, 32'h0);
        tick();
        b0.start = 1'b1;
        tick();
        b0.start = 1'b0;
        check("fetch_busy", {31'b0, b0.busy}, 32'h1);

        instr0(4'h4, 1'b0, 12'h800, 1'b0);
        instr0(4'hB, 1'b0, 12'h010, 1'b0);
        instr0(4'hB, 1'b1, 12'h010, 1'b1);
        instr0(4'hA, 1'b0, 12'h020, 1'b1);
        instr0(4'h3, 1'b0, 12'h000, 1'b0);
        check("illegal_set", {31'b0, b0.illegal}, 32'h1);
        instr0(4'h5, 1'b0, 12'h400, 1'b0);
        check("illegal_sticky", {31'b0, b0.illegal}, 32'h1);
        instr0(4'hF, 1'b0, 12'h001, 1'b0);
        check("halted_state", {29'b0, b0.halted, b0.busy, b0.illegal}, 32'h5);

        // EXEC_CYC=3 instance: en dropped for two cycles mid-execute, then a halt.
        b3.start = 1'b1;
        tick();
        b3.start = 1'b0;
        f = cyc;
        b3.ir = 4'h8;
        q3.push_back('{f,     12'h000, 1'b1, 1'b1, 1'b0});
        q3.push_back('{f + 2, 12'h080, 1'b0, 1'b0, 1'b0});
        q3.push_back('{f + 5, 12'h080, 1'b0, 1'b0, 1'b0});
        q3.push_back('{f + 6, 12'h080, 1'b0, 1'b0, 1'b0});
        q3.push_back('{f + 7, 12'h000, 1'b1, 1'b1, 1'b0});
        q3.push_back('{f + 9, 12'h001, 1'b0, 1'b0, 1'b0});
        q3.push_back('{f + 10, 12'h001, 1'b0, 1'b0, 1'b0});
        q3.push_back('{f + 11, 12'h001, 1'b0, 1'b0, 1'b0});
        repeat (3) tick();
        b3.en = 1'b0;
        check("en_low_busy", {30'b0, b3.busy, b3.halted}, 32'h2);
        tick();
        check("en_low_dec", {20'b0, b3.dec}, 32'h0);
        tick();
        b3.en = 1'b1;
        repeat (2) tick();
        b3.ir = 4'hF;
        repeat (5) tick();
        check("dut3_halted", {29'b0, b3.halted, b3.busy, b3.illegal}, 32'h4);
        check("dut0_still_halted", {31'b0, b0.halted}, 32'h1);

        b0.start = 1'b1;
        tick();
        b0.start = 1'b0;
        check("restart_clears_illegal", {30'b0, b0.illegal, b0.busy}, 32'h1);
        instr0(4'h4, 1'b0, 12'h800, 1'b0);

        // FETCH stalled four cycles, then reset hits in EXEC.
        f = cyc;
        b0.mem_rdy = 1'b0;
        b0.ir = 4'h8;
        q0.push_back('{f + 4, 12'h000, 1'b1, 1'b1, 1'b0});
        q0.push_back('{f + 6, 12'h080, 1'b0, 1'b0, 1'b0});
        repeat (4) tick();
        check("stall_busy", {31'b0, b0.busy}, 32'h1);
        b0.mem_rdy = 1'b1;
        repeat (2) tick();
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_reset_outputs", {14'b0, outs0(), b0.busy, b0.halted, b0.illegal}, 32'h0);
        check("async_reset_dut3", {30'b0, b3.halted, b3.busy}, 32'h0);
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (3) tick();
        check("idle_after_reset", {14'b0, outs0(), b0.busy, b0.halted, b0.illegal}, 32'h0);
        tick();
        check("q0_drained", q0.size(), 0);
        check("q3_drained", q3.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
